// File: rtl/alu_writeback_buffer_if.sv
// alu_writeback_buffer_if
// Bundles the writeback buffer's data-path signals:
//   - ALU result handshake : result_valid_i, result_ready_o, result_data_i, rd_addr_i
//   - register-file port   : rf_stall_i, rf_we_o, rf_waddr_o, rf_wdata_o
//   - forwarding lookup    : fwd_addr_i, fwd_hit_o, fwd_data_o
//   - occupancy            : count_o
// The _i/_o suffixes are as seen from the buffer. The slave modport is the
// buffer itself; the master modport is the surrounding pipeline (or a bench).
interface alu_writeback_buffer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4
);
    logic                        result_valid_i;
    logic                        result_ready_o;
    logic [DATA_WIDTH-1:0]       result_data_i;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr_i;
    logic                        rf_stall_i;
    logic                        rf_we_o;
    logic [REG_ADDR_WIDTH-1:0]   rf_waddr_o;
    logic [DATA_WIDTH-1:0]       rf_wdata_o;
    logic [REG_ADDR_WIDTH-1:0]   fwd_addr_i;
    logic                        fwd_hit_o;
    logic [DATA_WIDTH-1:0]       fwd_data_o;
    logic [$clog2(DEPTH):0]      count_o;

    modport master (
        output result_valid_i, result_data_i, rd_addr_i, rf_stall_i, fwd_addr_i,
        input  result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               fwd_hit_o, fwd_data_o, count_o
    );

    modport slave (
        input  result_valid_i, result_data_i, rd_addr_i, rf_stall_i, fwd_addr_i,
        output result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               fwd_hit_o, fwd_data_o, count_o
    );
endinterface

// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer
// Writeback stage behind the ALU. Accepts (rd, result) pairs via valid/ready,
// holds them in an in-order FIFO of DEPTH entries, drains one per cycle to the
// register-file write port when it is not stalled, and answers a youngest-match
// forwarding lookup over all pending entries.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   wb   - alu_writeback_buffer_if.slave (handshake, rf port, forwarding, count)
// Writes to x0 complete the handshake but are never enqueued. A full buffer
// refuses new results even when the head retires in the same cycle.
module alu_writeback_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_writeback_buffer_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0]          valid_q;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic full;
    logic empty;
    logic ready;
    logic accept;
    logic push;
    logic pop;

    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      fwd_idx;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign ready  = !full && !rst;
    assign accept = wb.result_valid_i && ready;
    // x0 results are acknowledged but dropped.
    assign push   = accept && (wb.rd_addr_i != '0);
    assign pop    = !rst && !empty && !wb.rf_stall_i;

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            // push and pop never share a slot: that needs empty (no pop) or full (no push)
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; valid_q/count qualify every read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= wb.rd_addr_i;
            data_q[wr_ptr] <= wb.result_data_i;
        end
    end

    // Youngest-match forwarding: walk from head (oldest) toward the tail so the
    // last match seen is the youngest. The retiring head still participates.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && valid_q[fwd_idx] &&
                (addr_q[fwd_idx] == wb.fwd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
        if (rst || (wb.fwd_addr_i == '0)) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

    assign wb.result_ready_o = ready;
    assign wb.rf_we_o        = pop;
    assign wb.rf_waddr_o     = (rst || empty) ? '0 : addr_q[rd_ptr];
    assign wb.rf_wdata_o     = (rst || empty) ? '0 : data_q[rd_ptr];
    assign wb.fwd_hit_o      = fwd_hit;
    assign wb.fwd_data_o     = fwd_data;
    assign wb.count_o        = rst ? '0 : count;

    a_depth_legal: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && full));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer
// Bench for alu_writeback_buffer: a directed per-cycle vector table, randomized
// traffic against a queue-based reference model, and hand-written streaming
// and reset-mid-operation sequences.
module tb_alu_writeback_buffer;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_writeback_buffer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    alu_writeback_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic          rst, v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          st;
        logic [AW-1:0] f;
        logic          rdy, we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          hit;
        logic [DW-1:0] fd;
        int            cnt;
    } vec_t;
    vec_t tbl[16];

    function automatic vec_t mk(logic r, logic v, logic [AW-1:0] a, logic [DW-1:0] d,
                                logic st, logic [AW-1:0] f, logic rdy, logic we,
                                logic [AW-1:0] wa, logic [DW-1:0] wd, logic hit,
                                logic [DW-1:0] fd, int cnt);
        vec_t t;
        t.rst = r; t.v = v; t.a = a; t.d = d; t.st = st; t.f = f;
        t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.hit = hit; t.fd = fd; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then settle to mid-cycle.
    task automatic apply(input logic r, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic st, input logic [AW-1:0] f);
        rst = r;
        bus.result_valid_i = v;
        bus.rd_addr_i = a;
        bus.result_data_i = d;
        bus.rf_stall_i = st;
        bus.fwd_addr_i = f;
        #4;
    endtask

    // Reference model: outputs follow directly from queue contents.
    task automatic check_model(input string tag);
        int            n;
        logic          e_hit;
        logic [DW-1:0] e_fd;
        n = q.size();
        e_hit = 1'b0;
        e_fd  = '0;
        if (!rst && bus.fwd_addr_i != 0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].a == bus.fwd_addr_i) begin
                    e_hit = 1'b1;
                    e_fd  = q[i].d;
                    break;
                end
            end
        end
        chk({tag, ".ready"}, 64'(bus.result_ready_o), 64'(!rst && n < DEPTH));
        chk({tag, ".we"},    64'(bus.rf_we_o), 64'(!rst && n > 0 && !bus.rf_stall_i));
        chk({tag, ".waddr"}, 64'(bus.rf_waddr_o), (!rst && n > 0) ? 64'(q[0].a) : 64'd0);
        chk({tag, ".wdata"}, 64'(bus.rf_wdata_o), (!rst && n > 0) ? 64'(q[0].d) : 64'd0);
        chk({tag, ".hit"},   64'(bus.fwd_hit_o), 64'(e_hit));
        chk({tag, ".fdata"}, 64'(bus.fwd_data_o), 64'(e_fd));
        chk({tag, ".count"}, 64'(bus.count_o), rst ? 64'd0 : 64'(n));
    endtask

    // Advance through the clock edge and evolve the model with the held inputs.
    task automatic tick();
        logic do_pop;
        logic do_acc;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            do_pop = (q.size() > 0) && !bus.rf_stall_i;
            do_acc = bus.result_valid_i && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_acc && bus.rd_addr_i != 0) q.push_back('{a: bus.rd_addr_i, d: bus.result_data_i});
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] prev_d;
        logic [AW-1:0] prev_a;
        logic          st;

        rst = 1'b1;
        bus.result_valid_i = 1'b0;
        bus.rd_addr_i = '0;
        bus.result_data_i = '0;
        bus.rf_stall_i = 1'b0;
        bus.fwd_addr_i = '0;
        #1;

        //          rst v  a  data          st f  | rdy we wa wdata         hit fdata         cnt
        tbl[0]  = mk(1, 0, 0, 0,            0, 0,   0,  0, 0, 0,            0,  0,            0);
        tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 5,   1,  0, 0, 0,            0,  0,            0);
        tbl[2]  = mk(0, 0, 0, 0,            0, 5,   1,  1, 5, 32'hDEADBEEF, 1,  32'hDEADBEEF, 1);
        tbl[3]  = mk(0, 0, 0, 0,            0, 5,   1,  0, 0, 0,            0,  0,            0);
        tbl[4]  = mk(0, 1, 0, 32'h1234,     0, 0,   1,  0, 0, 0,            0,  0,            0);
        tbl[5]  = mk(0, 0, 0, 0,            0, 0,   1,  0, 0, 0,            0,  0,            0);
        tbl[6]  = mk(0, 1, 7, 32'hA,        1, 7,   1,  0, 0, 0,            0,  0,            0);
        tbl[7]  = mk(0, 1, 7, 32'hB,        1, 7,   1,  0, 7, 32'hA,        1,  32'hA,        1);
        tbl[8]  = mk(0, 1, 3, 32'hC,        1, 7,   1,  0, 7, 32'hA,        1,  32'hB,        2);
        tbl[9]  = mk(0, 1, 4, 32'hD,        1, 8,   1,  0, 7, 32'hA,        0,  0,            3);
        tbl[10] = mk(0, 1, 9, 32'hE,        1, 0,   0,  0, 7, 32'hA,        0,  0,            4);
        tbl[11] = mk(0, 1, 9, 32'hE,        0, 4,   0,  1, 7, 32'hA,        1,  32'hD,        4);
        tbl[12] = mk(0, 0, 0, 0,            0, 7,   1,  1, 7, 32'hB,        1,  32'hB,        3);
        tbl[13] = mk(0, 0, 0, 0,            0, 3,   1,  1, 3, 32'hC,        1,  32'hC,        2);
        tbl[14] = mk(0, 0, 0, 0,            0, 0,   1,  1, 4, 32'hD,        0,  0,            1);
        tbl[15] = mk(0, 0, 0, 0,            1, 4,   1,  0, 0, 0,            0,  0,            0);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].f);
            chk($sformatf("vec%0d.ready", i), 64'(bus.result_ready_o), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d.we", i),    64'(bus.rf_we_o),        64'(tbl[i].we));
            chk($sformatf("vec%0d.waddr", i), 64'(bus.rf_waddr_o),     64'(tbl[i].wa));
            chk($sformatf("vec%0d.wdata", i), 64'(bus.rf_wdata_o),     64'(tbl[i].wd));
            chk($sformatf("vec%0d.hit", i),   64'(bus.fwd_hit_o),      64'(tbl[i].hit));
            chk($sformatf("vec%0d.fdata", i), 64'(bus.fwd_data_o),     64'(tbl[i].fd));
            chk($sformatf("vec%0d.count", i), 64'(bus.count_o),        64'(tbl[i].cnt));
            tick();
        end

        // Randomized traffic with alternating stall-heavy and stall-light phases.
        apply(1, 0, 0, 0, 0, 0);
        check_model("rnd_rst");
        tick();
        for (int i = 0; i < 3000; i++) begin
            st = ((i % 200) < 60) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                  AW'($urandom_range(0, 7)), $urandom, st, AW'($urandom_range(0, 7)));
            check_model("rnd");
            tick();
        end

        // Streaming: a push every cycle drains one cycle behind with matching payload.
        apply(1, 0, 0, 0, 0, 0);
        tick();
        prev_a = '0;
        prev_d = '0;
        for (int i = 0; i < 12; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'(1 + (i % 31));
            d = $urandom;
            apply(0, 1, a, d, 0, 0);
            check_model("stream");
            chk("stream.ready", 64'(bus.result_ready_o), 64'd1);
            if (i > 0) begin
                chk("stream.count", 64'(bus.count_o), 64'd1);
                chk("stream.waddr", 64'(bus.rf_waddr_o), 64'(prev_a));
                chk("stream.wdata", 64'(bus.rf_wdata_o), 64'(prev_d));
            end
            prev_a = a;
            prev_d = d;
            tick();
        end

        // Reset mid-operation: three buffered entries are discarded unwritten.
        apply(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, AW'(10 + i), DW'(32'h100 + i), 1, 0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 10);
        chk("rstmid.we_in_rst", 64'(bus.rf_we_o), 64'd0);
        chk("rstmid.hit_in_rst", 64'(bus.fwd_hit_o), 64'd0);
        chk("rstmid.ready_in_rst", 64'(bus.result_ready_o), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 10);
            chk("rstmid.count", 64'(bus.count_o), 64'd0);
            chk("rstmid.we", 64'(bus.rf_we_o), 64'd0);
            chk("rstmid.hit", 64'(bus.fwd_hit_o), 64'd0);
            tick();
        end
        apply(0, 1, 13, 32'hCAFE_F00D, 0, 0);
        check_model("rstmid.push");
        tick();
        apply(0, 0, 0, 0, 0, 13);
        chk("rstmid.post_we", 64'(bus.rf_we_o), 64'd1);
        chk("rstmid.post_waddr", 64'(bus.rf_waddr_o), 64'd13);
        chk("rstmid.post_wdata", 64'(bus.rf_wdata_o), 64'h0000_0000_CAFE_F00D);
        check_model("rstmid.post");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
